// File: rtl/reflet_float_mult_seq.sv
// reflet_float_mult_seq: iterative shift-add IEEE-754 multiplier (binary16/32/64) with
// round-to-nearest-even, special-value handling and valid/ready handshakes.
module reflet_float_mult_seq #(
  parameter int float_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [float_size-1:0] in1,
  input  logic [float_size-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [float_size-1:0] mult,
  output logic                  flag_overflow,
  output logic                  flag_underflow,
  output logic                  flag_invalid
);
  localparam int E    = float_size == 16 ? 5 : float_size == 64 ? 11 : 8;
  localparam int M    = float_size == 16 ? 10 : float_size == 64 ? 52 : 23;
  localparam int W    = 2 * M + 2;
  localparam int CW   = $clog2(M + 1);
  localparam int BIAS = 2 ** (E - 1) - 1;
  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
  state_t                state_q, state_d;
  logic [M:0]            a_q, a_d, b_q, b_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [E+1:0]          exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [float_size-1:0] mult_q, mult_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic                  s1, s2;
  logic [E-1:0]          e1, e2;
  logic [M-1:0]          m1, m2;
  logic                  z1, z2, inf1, inf2, nan1, nan2, invalid, special;
  logic [M+1:0]          sum;
  logic [W-2:0]          ps;
  logic                  norm, rnd, carry, ovf, unf;
  logic [M-1:0]          mant;
  logic [M:0]            mant_r;
  logic [E+1:0]          exp_f;
  assign {s1, e1, m1} = in1;
  assign {s2, e2, m2} = in2;
  assign z1      = e1 == '0;
  assign z2      = e2 == '0;
  assign inf1    = &e1 && m1 == '0;
  assign inf2    = &e2 && m2 == '0;
  assign nan1    = &e1 && |m1;
  assign nan2    = &e2 && |m2;
  assign invalid = nan1 || nan2 || (inf1 && z2) || (inf2 && z1);
  assign special = invalid || inf1 || inf2 || z1 || z2;
  assign sum     = {1'b0, acc_q[W-1:M+1]} + {1'b0, b_q[0] ? a_q : '0};
  // Product lies in [1,4): align so the leading one sits just above ps[2M].
  assign norm    = acc_q[W-1];
  assign ps      = norm ? acc_q[W-2:0] : {acc_q[W-3:0], 1'b0};
  assign mant    = ps[2*M:M+1];
  assign rnd     = ps[M] && (|ps[M-1:0] || mant[0]);
  assign mant_r  = {1'b0, mant} + (M+1)'(rnd);
  assign carry   = mant_r[M];
  assign exp_f   = exp_q + (E+2)'(norm) + (E+2)'(carry);
  assign ovf     = !exp_f[E+1] && exp_f[E:0] >= (E+1)'(2 ** E - 1);
  assign unf     = exp_f[E+1] || exp_f == '0;
  assign in_ready       = state_q == IDLE && !reset;
  assign out_valid      = state_q == DONE;
  assign mult           = mult_q;
  assign flag_overflow  = ovf_q;
  assign flag_underflow = unf_q;
  assign flag_invalid   = inv_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    mult_d  = mult_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inv_d  = invalid;
        sign_d = s1 ^ s2;
        a_d    = {1'b1, m1};
        b_d    = {1'b1, m2};
        acc_d  = '0;
        cnt_d  = CW'(M);
        exp_d  = {2'b0, e1} + {2'b0, e2} - (E+2)'(BIAS);
        mult_d = invalid ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} :
                 (inf1 || inf2) ? {s1 ^ s2, {E{1'b1}}, {M{1'b0}}} : {s1 ^ s2, {(E+M){1'b0}}};
        state_d = special ? DONE : MULT;
      end
      MULT: begin
        acc_d   = {sum, acc_q[M:1]};
        b_d     = b_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? NORM : MULT;
      end
      NORM: begin
        ovf_d   = ovf;
        unf_d   = unf;
        mult_d  = ovf ? {sign_q, {E{1'b1}}, {M{1'b0}}} :
                  unf ? {sign_q, {(E+M){1'b0}}} : {sign_q, exp_f[E-1:0], mant_r[M-1:0]};
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      mult_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      mult_q  <= mult_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
    end
  end
endmodule

// File: tb/tb_reflet_float_mult_seq.sv
// tb_reflet_float_mult_seq: directed checks of the multiplier at binary16, binary32 and binary64,
// sharing one stimulus bus steered to the selected instance.
module tb_reflet_float_mult_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [1:0]  sel = 2'd1;
  logic [63:0] opa = '0, opb = '0;
  logic        ir16, ir32, ir64, ov16, ov32, ov64;
  logic [15:0] m16;
  logic [31:0] m32;
  logic [63:0] m64;
  logic [2:0]  f16, f32, f64;
  logic        ir, ov;
  logic [63:0] res;
  logic [2:0]  fl;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  reflet_float_mult_seq #(.float_size(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 2'd0), .in_ready(ir16),
    .in1(opa[15:0]), .in2(opb[15:0]), .out_valid(ov16), .out_ready(ordy), .mult(m16),
    .flag_overflow(f16[2]), .flag_underflow(f16[1]), .flag_invalid(f16[0]));
  reflet_float_mult_seq #(.float_size(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 2'd1), .in_ready(ir32),
    .in1(opa[31:0]), .in2(opb[31:0]), .out_valid(ov32), .out_ready(ordy), .mult(m32),
    .flag_overflow(f32[2]), .flag_underflow(f32[1]), .flag_invalid(f32[0]));
  reflet_float_mult_seq #(.float_size(64)) u64 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 2'd2), .in_ready(ir64),
    .in1(opa), .in2(opb), .out_valid(ov64), .out_ready(ordy), .mult(m64),
    .flag_overflow(f64[2]), .flag_underflow(f64[1]), .flag_invalid(f64[0]));
  always_comb begin
    ir  = sel == 2'd0 ? ir16 : sel == 2'd1 ? ir32 : ir64;
    ov  = sel == 2'd0 ? ov16 : sel == 2'd1 ? ov32 : ov64;
    res = sel == 2'd0 ? {48'b0, m16} : sel == 2'd1 ? {32'b0, m32} : m64;
    fl  = sel == 2'd0 ? f16 : sel == 2'd1 ? f32 : f64;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  // fl_e is {overflow, underflow, invalid}; hold is the number of cycles out_ready stays low.
  task automatic op(input string tag, input logic [1:0] s, input logic [63:0] x, input logic [63:0] y,
                    input logic [63:0] exp, input logic [2:0] fl_e, input int lat, input int hold);
    int n;
    logic ok;
    @(negedge clk);
    sel = s;
    opa = x;
    opb = y;
    chk({tag, ".in_ready_idle"}, 64'(ir), 64'd1);
    iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (ov) break;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".mult"}, res, exp);
    chk({tag, ".flags"}, 64'(fl), 64'(fl_e));
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 ok = ok && ov && !ir && res === exp && fl === fl_e;
    end
    if (hold > 0) chk({tag, ".held"}, 64'(ok), 64'd1);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk({tag, ".released"}, {62'b0, ov, ir}, 64'b01);
  endtask
  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", {ov16, ov32, ov64, ir16, ir32, ir64}, 64'd0);
    chk("reset.mult", {m16, m32, 16'b0} | m64, 64'd0);
    chk("reset.flags", {f16, f32, f64}, 64'd0);
    reset = 1'b0;
    op("basic",   2'd1, 64'h40000000, 64'h40400000, 64'h40C00000, 3'b000, 25, 10);
    op("norm",    2'd1, 64'h3FC00000, 64'h3FC00000, 64'h40100000, 3'b000, 25, 0);
    op("round",   2'd1, 64'h3F800001, 64'h3F800001, 64'h3F800002, 3'b000, 25, 0);
    op("tie",     2'd1, 64'h3F800001, 64'h3FC00000, 64'h3FC00002, 3'b000, 25, 0);
    op("infzero", 2'd1, 64'h7F800000, 64'h00000000, 64'h7FC00000, 3'b001, 1, 3);
    op("nan",     2'd1, 64'h7FC00000, 64'h3F800000, 64'h7FC00000, 3'b001, 1, 0);
    op("neginf",  2'd1, 64'hFF800000, 64'h40000000, 64'hFF800000, 3'b000, 1, 0);
    op("denorm",  2'd1, 64'h00000001, 64'h40000000, 64'h00000000, 3'b000, 1, 0);
    op("negzero", 2'd1, 64'h80000000, 64'h3F800000, 64'h80000000, 3'b000, 1, 0);
    op("ovf",     2'd1, 64'h7F000000, 64'h7F000000, 64'h7F800000, 3'b100, 25, 0);
    op("unf",     2'd1, 64'h00800000, 64'h00800000, 64'h00000000, 3'b010, 25, 0);
    op("negmul",  2'd1, 64'hC0000000, 64'h40400000, 64'hC0C00000, 3'b000, 25, 0);
    @(negedge clk);
    sel = 2'd1;
    opa = 64'h40000000;
    opb = 64'h40400000;
    iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset.state", {62'b0, ov32, ir32}, 64'd0);
    chk("midreset.mult", 64'(m32), 64'd0);
    reset = 1'b0;
    #1;
    chk("midreset.ready", 64'(ir32), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 seen = seen || ov32;
    end
    chk("midreset.nostale", 64'(seen), 64'd0);
    op("h.basic", 2'd0, 64'h4000, 64'h4200, 64'h4600, 3'b000, 12, 0);
    op("h.ovf",   2'd0, 64'h7800, 64'h7800, 64'h7C00, 3'b100, 12, 0);
    op("d.basic", 2'd2, 64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 3'b000, 54, 0);
    op("d.inf",   2'd2, 64'h7FF0000000000000, 64'hBFF0000000000000, 64'hFFF0000000000000, 3'b000, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reflet_float_mult_seq.md
Name: reflet_float_mult_seq

Overview:
- Sequential, handshaked floating-point multiplier for the reflet FPU.
- Handles IEEE-754 binary16, binary32 and binary64 operands, selected by parameter.
- Uses an iterative shift-add mantissa multiplier with round-to-nearest-even, and handles zero, infinity, NaN and denormal inputs.
- Raises overflow, underflow and invalid flags; the FPU operation dispatcher drives it through valid/ready handshakes.

Parameters:
- float_size, 32, total width; legal values 16, 32, 64.
- E = 5/8/11 and M = 10/23/52 (exponent and mantissa widths) follow from float_size; bias = 2^(E-1)-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in1  in  float_size  operand A.
- in2  in  float_size  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- mult  out  float_size  product.
- flag_overflow  out  1  result saturated to infinity.
- flag_underflow  out  1  result flushed to zero.
- flag_invalid  out  1  NaN result produced.

Behaviour:
- Reset (sampled at clk edge): state=IDLE, out_valid=0, mult=0, all flags=0, counter=0, accumulator=0. in_ready=0 while reset=1. Reset mid-operation discards the operation; no output is produced for it.
- in_ready = (state==IDLE) && !reset. Operands are accepted on an edge where in_valid && in_ready; in1/in2 are registered at that edge (call it edge t).
- States: IDLE, MULT, NORM, DONE.
- Special-case detection at acceptance:
  - Denormal input (exp==0, mnt!=0) is treated as zero.
  - NaN in, or inf times zero: result 0 / exp all-ones / mantissa MSB=1, rest 0 (canonical qNaN, sign 0); flag_invalid=1.
  - inf times nonzero: signed inf.
  - Zero times finite: signed zero (sign = sign1^sign2).
  - Specials go IDLE→DONE, so out_valid=1 from edge t+1.
- Normal path:
  - IDLE→MULT. Multiplicand {1,mntA} and multiplier {1,mntB}; counter loads M.
  - Each MULT cycle examines one multiplier bit (LSB first). It conditionally adds the multiplicand into a 2M+2-bit accumulator, then shifts. The counter decrements; when it reaches 0 the state goes to NORM.
  - MULT lasts exactly M+1 cycles.
  - NORM (1 cycle):
    - If product MSB=1, shift right 1 and add 1 to the exponent.
    - Take M mantissa bits plus guard bit G and sticky S (OR of the rest).
    - Round up if G && (S || lsb). A mantissa carry-out increments the exponent and zeroes the mantissa.
    - Exponent math uses E+2 signed bits: expA+expB-bias+norm+carry.
    - Final exp ≥ 2^E-1: signed inf, flag_overflow=1.
    - Final exp ≤ 0: signed zero, flag_underflow=1.
  - NORM→DONE, so out_valid=1 from edge t+M+2 (25 cycles for binary32).
- DONE:
  - mult and flags are held stable while out_valid=1.
  - The handshake completes on an edge with out_valid && out_ready. That edge moves to IDLE and clears out_valid. mult and flags keep their last values until the next DONE.
  - No new operand can be accepted in the same cycle, since in_ready=0 in DONE.
- Flags are cleared at acceptance and are valid only while out_valid=1.
- in_valid, in1 and in2 are ignored outside IDLE. out_ready is ignored outside DONE.

Test Plan:
- Basic product: 0x40000000 × 0x40400000 → mult=0x40C00000, no flags, out_valid exactly 25 cycles after accept edge.
- Normalisation: 0x3FC00000 × 0x3FC00000 → 0x40100000. Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002. Tie-to-even: 0x3F800001 × 0x3FC00000 → 0x3FC00002.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flag_invalid=1, out_valid at t+1.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x00000001 × 0x40000000 → 0x00000000.
- Range limits: 0x7F000000 × 0x7F000000 → 0x7F800000, flag_overflow=1. 0x00800000 × 0x00800000 → 0x00000000, flag_underflow=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - mult stays stable and in_ready stays 0 throughout.
  - When out_ready rises, the next edge clears out_valid and in_ready returns to 1.
  - Back-to-back operations produce correct, independent results.
- Reset and width:
  - Assert reset at MULT cycle 10: next edge gives state IDLE, out_valid=0, mult=0; no stale result later appears.
  - Repeat with float_size=16: 0x4000 × 0x4200 → 0x4600, latency 12 cycles.
  - Repeat with float_size=64: 0x4000000000000000 × 0x4008000000000000 → 0x4018000000000000, latency 54 cycles.
